// File: rtl/spi_pkg.sv
// Shared types for the SPI master.
//   spi_state_t : transfer sequencer states
//   spi_mode_t  : clock polarity/phase latched when a transfer is accepted
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator for the SPI master.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   en   : count enable; the counter is cleared while low
//   tick : registered one-cycle pulse, once every CLK_DIV enabled cycles
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // tick is registered, so every phase boundary lands one cycle after the
  // counter wraps; this supplies the extra accept cycle in the overall latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (cnt_q == CntMax);
      cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/spi_master_nch.sv
// Parametrised SPI master with runtime CPOL/CPHA and NUM_CS active-low selects.
//   clk, rst        : system clock, asynchronous active-high reset
//   start           : transfer request, accepted only while busy is low
//   cpol, cpha      : SPI mode, latched at accept
//   cs_sel          : slave index, latched at accept (out of range -> no select)
//   tx_data         : word to send MSB first, latched at accept
//   busy, done      : busy from the cycle after accept through the done cycle;
//                     done is a one-cycle end-of-transfer pulse
//   rx_data         : received word, updated with done
//   sclk, mosi, miso: SPI bus
//   cs_n            : active-low chip selects
module spi_master_nch
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_CS  = 1,
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W - 1);

  spi_state_t        state_q;
  spi_mode_t         mode_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [EdgeW-1:0]  edge_cnt_q;
  logic [NUM_CS-1:0] cs_dec;
  logic              tick;
  logic              edge_odd;
  logic              edge_last;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .tick(tick)
  );

  // One-hot-low select; an out-of-range index leaves every line high.
  always_comb begin
    cs_dec = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  // edge_cnt_q counts completed edges, so the edge about to happen is odd when it is even.
  assign edge_odd  = ~edge_cnt_q[0];
  assign edge_last = (edge_cnt_q == LastEdge);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      edge_cnt_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rx_data    <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= '1;
    end else begin
      done <= 1'b0;
      // busy spans the done cycle, which is what blocks a start presented alongside done.
      if (done) busy <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !busy) begin
            mode_q.cpol <= cpol;
            mode_q.cpha <= cpha;
            tx_sh_q     <= tx_data;
            mosi        <= tx_data[DATA_W-1];
            sclk        <= cpol;
            cs_n        <= cs_dec;
            edge_cnt_q  <= '0;
            busy        <= 1'b1;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (tick) state_q <= XFER;
        end
        XFER: begin
          if (tick) begin
            sclk       <= edge_last ? mode_q.cpol : ~sclk;
            edge_cnt_q <= edge_cnt_q + EdgeW'(1);
            if (edge_odd != mode_q.cpha) begin
              rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};
            end else if (mode_q.cpha) begin
              // Odd edges in mode cpha=1: the first re-drives the MSB already on mosi.
              mosi    <= tx_sh_q[DATA_W-1];
              tx_sh_q <= tx_sh_q << 1;
            end else if (!edge_last) begin
              mosi    <= tx_sh_q[DATA_W-2];
              tx_sh_q <= tx_sh_q << 1;
            end
            if (edge_last) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n    <= '1;
            done    <= 1'b1;
            rx_data <= rx_sh_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_nch.sv
// Self-checking bench: instance A (8-bit, 4 selects, divide-by-4) against an SPI
// slave model; instance B (16-bit, 1 select, divide-by-2) in loopback.
module tb_spi_master_nch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A ----------------
  logic       start_a = 0, cpol_a = 0, cpha_a = 0;
  logic [1:0] cs_sel_a = 0;
  logic [7:0] tx_a = 0, rx_a;
  logic       busy_a, done_a, sclk_a, mosi_a, miso_a;
  logic [3:0] cs_n_a;

  spi_master_nch #(.DATA_W(8), .NUM_CS(4), .CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cpol(cpol_a), .cpha(cpha_a),
    .cs_sel(cs_sel_a), .tx_data(tx_a), .busy(busy_a), .done(done_a), .rx_data(rx_a),
    .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a)
  );

  // Slave model state for A
  logic       cur_cpol_a = 0, cur_cpha_a = 0;
  logic [1:0] cur_sel_a = 0;
  logic [7:0] slv_a = 0, cap_a = 0;
  bit         loop_a = 0;
  int         idx_a = 0, edges_a = 0, cs_low_a = 0, cs_bad_a = 0, dones_a = 0;
  logic       sclk_prev_a = 0, busy_prev_a = 0;

  function automatic logic slave_bit(input logic [7:0] w, input int idx);
    if (idx < 0 || idx > 7) return 1'b0;
    return w[7-idx];
  endfunction

  assign miso_a = loop_a ? mosi_a : slave_bit(slv_a, idx_a);

  // Slave: captures mosi on sample edges, advances its output bit on the other edges.
  always @(negedge clk) begin
    if (busy_a && busy_prev_a && (sclk_a != sclk_prev_a)) begin
      edges_a++;
      if ((sclk_prev_a == cur_cpol_a) != cur_cpha_a) cap_a = {cap_a[6:0], mosi_a};
      else idx_a++;
    end
    if (cs_n_a != 4'hF) begin
      cs_low_a++;
      if (cs_n_a != ~(4'b0001 << cur_sel_a)) cs_bad_a++;
    end
    if (done_a) dones_a++;
    sclk_prev_a = sclk_a;
    busy_prev_a = busy_a;
  end

  // Must be called at a negedge; returns at the negedge after the done cycle.
  task automatic xfer_a(input logic pol, input logic pha, input logic [1:0] sel,
                        input logic [7:0] tx, input logic [7:0] slv, input bit loop,
                        input bit poke);
    int k;
    int guard;
    guard = 0;
    while (busy_a && guard < 200) begin @(negedge clk); guard++; end
    cpol_a = pol; cpha_a = pha; cs_sel_a = sel; tx_a = tx;
    cur_cpol_a = pol; cur_cpha_a = pha; cur_sel_a = sel;
    slv_a = slv; loop_a = loop; idx_a = pha ? -1 : 0;
    cap_a = 0; edges_a = 0; cs_low_a = 0; dones_a = 0;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    k = 0;
    while (!done_a && k < 300) begin
      start_a = poke && (k == 10);
      @(negedge clk);
      k++;
    end
    start_a = 0;
    check_eq("a_latency", 32'(k), 32'd73);
    check_eq("a_rx_data", 32'(rx_a), 32'(loop ? tx : slv));
    check_eq("a_mosi_bits", 32'(cap_a), 32'(tx));
    check_eq("a_sclk_edges", 32'(edges_a), 32'd16);
    check_eq("a_cs_low_cycles", 32'(cs_low_a), 32'd73);
    check_eq("a_busy_in_done", 32'(busy_a), 32'd1);
    start_a = poke;
    @(negedge clk);
    start_a = 0;
    check_eq("a_busy_after", 32'(busy_a), 32'd0);
    check_eq("a_done_width", 32'(done_a), 32'd0);
    check_eq("a_done_count", 32'(dones_a), 32'd1);
    check_eq("a_sclk_idle", 32'(sclk_a), 32'(pol));
    check_eq("a_cs_idle", 32'(cs_n_a), 32'hF);
    check_eq("a_cs_onehot", 32'(cs_bad_a), 32'd0);
  endtask

  task automatic abort_a();
    cpol_a = 1; cpha_a = 0; cs_sel_a = 2'd1; tx_a = 8'h5A;
    cur_cpol_a = 1; cur_cpha_a = 0; cur_sel_a = 2'd1;
    loop_a = 1; idx_a = 0; dones_a = 0;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (30) @(negedge clk);
    rst = 1;
    #1;
    check_eq("rst_mid_cs_n", 32'(cs_n_a), 32'hF);
    check_eq("rst_mid_busy", 32'(busy_a), 32'd0);
    check_eq("rst_mid_sclk", 32'(sclk_a), 32'd0);
    check_eq("rst_mid_rx", 32'(rx_a), 32'd0);
    @(negedge clk);
    rst = 0;
    repeat (100) @(negedge clk);
    check_eq("rst_mid_no_done", 32'(dones_a), 32'd0);
    check_eq("rst_mid_idle", 32'(busy_a), 32'd0);
  endtask

  // ---------------- instance B ----------------
  logic        start_b = 0, cpol_b = 0, cpha_b = 0;
  logic [0:0]  cs_sel_b = 0;
  logic [15:0] tx_b = 0, rx_b;
  logic        busy_b, done_b, sclk_b, mosi_b;
  logic [0:0]  cs_n_b;
  int          edges_b = 0, cs_low_b = 0, dones_b = 0;
  logic        sclk_prev_b = 0, busy_prev_b = 0;

  spi_master_nch #(.DATA_W(16), .NUM_CS(1), .CLK_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cpol(cpol_b), .cpha(cpha_b),
    .cs_sel(cs_sel_b), .tx_data(tx_b), .busy(busy_b), .done(done_b), .rx_data(rx_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(mosi_b), .cs_n(cs_n_b)
  );

  always @(negedge clk) begin
    if (busy_b && busy_prev_b && (sclk_b != sclk_prev_b)) edges_b++;
    if (cs_n_b == 1'b0) cs_low_b++;
    if (done_b) dones_b++;
    sclk_prev_b = sclk_b;
    busy_prev_b = busy_b;
  end

  task automatic xfer_b(input logic pol, input logic pha, input logic sel, input logic [15:0] tx);
    int k;
    cpol_b = pol; cpha_b = pha; cs_sel_b = sel; tx_b = tx;
    edges_b = 0; cs_low_b = 0; dones_b = 0;
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    k = 0;
    while (!done_b && k < 300) begin @(negedge clk); k++; end
    check_eq("b_latency", 32'(k), 32'd69);
    check_eq("b_rx_loop", 32'(rx_b), 32'(tx));
    check_eq("b_sclk_edges", 32'(edges_b), 32'd32);
    check_eq("b_cs_low_cycles", 32'(cs_low_b), sel ? 32'd0 : 32'd69);
    @(negedge clk);
    check_eq("b_done_count", 32'(dones_b), 32'd1);
    check_eq("b_sclk_idle", 32'(sclk_b), 32'(pol));
    check_eq("b_busy_after", 32'(busy_b), 32'd0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_rx", 32'(rx_a), 32'd0);
    check_eq("rst_sclk", 32'(sclk_a), 32'd0);
    check_eq("rst_mosi", 32'(mosi_a), 32'd0);
    check_eq("rst_cs_n", 32'(cs_n_a), 32'hF);
    check_eq("rst_b_sclk", 32'(sclk_b), 32'd0);
    check_eq("rst_b_cs_n", 32'(cs_n_b), 32'd1);
    rst = 0;
    @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      logic [1:0] mv;
      mv = 2'(m);
      xfer_a(mv[1], mv[0], 2'd0, 8'hA5, 8'h00, 1'b1, 1'b0);
    end
    xfer_a(1'b0, 1'b0, 2'd0, 8'hC3, 8'h3C, 1'b0, 1'b0);
    xfer_a(1'b1, 1'b1, 2'd2, 8'h96, 8'h69, 1'b0, 1'b0);
    // Start pokes mid-transfer and on done, then back-to-back selects 3 -> 0.
    xfer_a(1'b0, 1'b1, 2'd3, 8'h17, 8'hE8, 1'b0, 1'b1);
    xfer_a(1'b1, 1'b0, 2'd0, 8'h81, 8'h7E, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      xfer_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    abort_a();
    xfer_a(1'b0, 1'b0, 2'd2, 8'h3E, 8'hD1, 1'b0, 1'b0);

    xfer_b(1'b1, 1'b0, 1'b1, 16'hBEEF);
    xfer_b(1'b1, 1'b1, 1'b0, 16'($urandom));
    xfer_b(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
